// File: rtl/awgn_sample_scheduler.sv
// ============================================================================
// awgn_sample_scheduler
// ----------------------------------------------------------------------------
// Controller and arbiter for the AWGN generator pipeline. It gates generator
// advance and discards the generator's warm-up output. It buffers (X0,X1)
// sample pairs in a small FIFO and hands them out round-robin to NREQ
// consumers, one pair per cycle.
//
// Parameters
//   NREQ      number of requesters (>= 2)
//   PIPE_LAT  generator latency in enabled clocks from first advance to
//             first valid sample
//   DEPTH     sample-pair FIFO depth (power of 2, >= 2)
//   W         sample width (sign-magnitude, bit W-1 = sign)
//
// Ports
//   clk        clock
//   reset      synchronous, active-low reset
//   en         run request from control
//   flush      clear FIFO contents (pipeline stays warm)
//   gen_x0/x1  generator samples
//   gen_valid  generator output valid
//   gen_run    generator clock-enable / advance (combinational from regs)
//   req        per-consumer request, held until granted
//   grant      one-hot grant, qualifies out_x0/out_x1 (single cycle)
//   out_x0/x1  granted sample pair
//   out_valid  |grant
//   warm       warm-up complete since last reset
//   level      FIFO occupancy
//   sample_cnt samples delivered, wraps modulo 2^32
// ============================================================================
module awgn_sample_scheduler #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned PIPE_LAT = 12,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned W        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      flush,
    input  logic [W-1:0]              gen_x0,
    input  logic [W-1:0]              gen_x1,
    input  logic                      gen_valid,
    output logic                      gen_run,
    input  logic [NREQ-1:0]           req,
    output logic [NREQ-1:0]           grant,
    output logic [W-1:0]              out_x0,
    output logic [W-1:0]              out_x1,
    output logic                      out_valid,
    output logic                      warm,
    output logic [$clog2(DEPTH):0]    level,
    output logic [31:0]               sample_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned RW = $clog2(NREQ);
    localparam int unsigned CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int unsigned PW = 2 * W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    // Registered state
    state_t          state;
    logic [CW-1:0]   wcnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [RW-1:0]   rr_ptr;
    logic [PW-1:0]   mem [DEPTH];

    // Next-state values
    state_t          state_n;
    logic [CW-1:0]   wcnt_n;
    logic [AW-1:0]   wr_ptr_n;
    logic [AW-1:0]   rd_ptr_n;
    logic [RW-1:0]   rr_ptr_n;
    logic            warm_n;
    logic [LW-1:0]   level_n;
    logic [NREQ-1:0] grant_n;
    logic [W-1:0]    out_x0_n;
    logic [W-1:0]    out_x1_n;
    logic            out_valid_n;
    logic [31:0]     sample_cnt_n;

    // Datapath helpers
    logic            push;
    logic            pop;
    logic [NREQ-1:0] elig;
    logic            win_found;
    logic [RW-1:0]   win_idx;
    int unsigned     scan_idx;
    logic [PW-1:0]   head;

    // Generator advance: always while warming up, in RUN only with FIFO room
    assign gen_run = (state == WARMUP) || ((state == RUN) && (level < LW'(DEPTH)));

    // Only RUN-state output is real; warm-up output is dropped on the floor
    assign push = (state == RUN) && gen_run && gen_valid;

    // A requester whose grant is being shown this cycle is not eligible again
    assign elig = req & ~grant;

    assign head = mem[rd_ptr];

    // Round-robin winner: first eligible requester at or above rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = (32'(rr_ptr) + k) % NREQ;
            if (!win_found && elig[RW'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = RW'(scan_idx);
            end
        end
    end

    assign pop = win_found && (level != '0) && !flush;

    // Next-state / output logic
    always_comb begin
        state_n      = state;
        wcnt_n       = wcnt;
        warm_n       = warm;
        wr_ptr_n     = wr_ptr;
        rd_ptr_n     = rd_ptr;
        rr_ptr_n     = rr_ptr;
        level_n      = level;
        grant_n      = '0;
        out_x0_n     = out_x0;
        out_x1_n     = out_x1;
        out_valid_n  = 1'b0;
        sample_cnt_n = sample_cnt;

        // Control FSM; warm-up completion takes priority over en dropping,
        // since the final advance has already happened that cycle
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_n = warm ? RUN : WARMUP;
                end
            end
            WARMUP: begin
                if (gen_run && (wcnt == CW'(PIPE_LAT - 1))) begin
                    state_n = RUN;
                    warm_n  = 1'b1;
                end else begin
                    if (gen_run) begin
                        wcnt_n = wcnt + CW'(1);
                    end
                    if (!en) begin
                        state_n = IDLE;
                    end
                end
            end
            RUN: begin
                if (!en) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // FIFO and grant; flush overrides any push or pop this cycle
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            level_n  = '0;
        end else begin
            if (push) begin
                wr_ptr_n = wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr_n     = rd_ptr + AW'(1);
                grant_n      = NREQ'(1) << win_idx;
                out_valid_n  = 1'b1;
                out_x0_n     = head[PW-1:W];
                out_x1_n     = head[W-1:0];
                rr_ptr_n     = (win_idx == RW'(NREQ - 1)) ? '0 : win_idx + RW'(1);
                sample_cnt_n = sample_cnt + 32'd1;
            end
            level_n = level + LW'(push) - LW'(pop);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wcnt       <= '0;
            warm       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rr_ptr     <= '0;
            level      <= '0;
            grant      <= '0;
            out_x0     <= '0;
            out_x1     <= '0;
            out_valid  <= 1'b0;
            sample_cnt <= '0;
        end else begin
            state      <= state_n;
            wcnt       <= wcnt_n;
            warm       <= warm_n;
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            rr_ptr     <= rr_ptr_n;
            level      <= level_n;
            grant      <= grant_n;
            out_x0     <= out_x0_n;
            out_x1     <= out_x1_n;
            out_valid  <= out_valid_n;
            sample_cnt <= sample_cnt_n;
        end
    end

    // Sample-pair storage; contents need no reset, pointers gate visibility
    always_ff @(posedge clk) begin
        if (reset && push && !flush) begin
            mem[wr_ptr] <= {gen_x0, gen_x1};
        end
    end

endmodule

// File: tb/tb_awgn_sample_scheduler.sv
// ============================================================================
// tb_awgn_sample_scheduler
// Self-checking bench: directed scenarios plus a randomized phase, all
// compared every cycle against a queue-based reference model.
// ============================================================================
module tb_awgn_sample_scheduler;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned PIPE_LAT = 12;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned W        = 16;
    localparam int unsigned LW       = $clog2(DEPTH) + 1;

    logic            clk;
    logic            reset;
    logic            en;
    logic            flush;
    logic [W-1:0]    gen_x0;
    logic [W-1:0]    gen_x1;
    logic            gen_valid;
    logic            gen_run;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    out_x0;
    logic [W-1:0]    out_x1;
    logic            out_valid;
    logic            warm;
    logic [LW-1:0]   level;
    logic [31:0]     sample_cnt;

    int checks = 0;
    int errors = 0;

    awgn_sample_scheduler #(
        .NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH), .W(W)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .gen_x0(gen_x0), .gen_x1(gen_x1), .gen_valid(gen_valid),
        .gen_run(gen_run), .req(req), .grant(grant),
        .out_x0(out_x0), .out_x1(out_x1), .out_valid(out_valid),
        .warm(warm), .level(level), .sample_cnt(sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 warming up, 2 running
    int              m_mode;
    bit              m_warm;
    int              m_runs;      // generator advances seen during warm-up
    logic [2*W-1:0]  m_q[$];
    int              m_rr;
    logic [NREQ-1:0] m_grant;
    logic [W-1:0]    m_x0;
    logic [W-1:0]    m_x1;
    logic [31:0]     m_cnt;
    bit              seen_1234;

    function automatic bit m_gen_run();
        return (m_mode == 1) || (m_mode == 2 && m_q.size() < DEPTH);
    endfunction

    task automatic model_update();
        logic [NREQ-1:0] elig;
        logic [2*W-1:0]  h;
        int              win;
        bit              push;
        if (!reset) begin
            m_mode = 0; m_warm = 0; m_runs = 0; m_q.delete(); m_rr = 0;
            m_grant = '0; m_x0 = '0; m_x1 = '0; m_cnt = '0;
            return;
        end
        push = (m_mode == 2) && m_gen_run() && gen_valid;
        elig = req & ~m_grant;
        win  = -1;
        if (!flush && m_q.size() > 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_rr + k) % NREQ;
                if (win < 0 && elig[idx]) win = idx;
            end
        end
        if (flush) begin
            m_q.delete();
            m_grant = '0;
        end else begin
            if (win >= 0) begin
                h = m_q.pop_front();
                m_x0 = h[2*W-1:W];
                m_x1 = h[W-1:0];
                m_grant = NREQ'(1) << win;
                m_rr = (win + 1) % NREQ;
                m_cnt = m_cnt + 32'd1;
            end else begin
                m_grant = '0;
            end
            if (push) m_q.push_back({gen_x0, gen_x1});
        end
        case (m_mode)
            0: if (en) m_mode = m_warm ? 2 : 1;
            1: begin
                if (m_runs == PIPE_LAT - 1) begin
                    m_mode = 2;
                    m_warm = 1;
                end else begin
                    m_runs++;
                    if (!en) m_mode = 0;
                end
            end
            default: if (!en) m_mode = 0;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("grant",      64'(grant),      64'(m_grant));
        chk("out_valid",  64'(out_valid),  64'(m_grant != '0));
        chk("out_x0",     64'(out_x0),     64'(m_x0));
        chk("out_x1",     64'(out_x1),     64'(m_x1));
        chk("warm",       64'(warm),       64'(m_warm));
        chk("level",      64'(level),      64'(m_q.size()));
        chk("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
        chk("gen_run",    64'(gen_run),    64'(m_gen_run()));
        if (out_x0 == 16'h1234) seen_1234 = 1'b1;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        v = W'($urandom);
        if (v == 16'h1234) v = 16'h1235;
        return v;
    endfunction

    task automatic warmup_count(output int runs);
        runs = 0;
        for (int i = 0; i < 40; i++) begin
            if (warm) break;
            if (gen_run) runs++;
            step();
        end
        chk("warm_reached", 64'(warm), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int runs;
        int ngr;
        logic [31:0] prev_cnt;

        reset = 1'b0; en = 1'b0; flush = 1'b0; gen_valid = 1'b0;
        gen_x0 = '0; gen_x1 = '0; req = '0; seen_1234 = 1'b0;
        m_mode = 0; m_warm = 0; m_runs = 0; m_rr = 0;
        m_grant = '0; m_x0 = '0; m_x1 = '0; m_cnt = '0;

        // T1: reset, then warm-up length
        for (int i = 0; i < 3; i++) step();
        chk("t1_rst_gen_run", 64'(gen_run),    64'd0);
        chk("t1_rst_level",   64'(level),      64'd0);
        chk("t1_rst_grant",   64'(grant),      64'd0);
        chk("t1_rst_warm",    64'(warm),       64'd0);
        chk("t1_rst_cnt",     64'(sample_cnt), 64'd0);
        chk("t1_rst_x0",      64'(out_x0),     64'd0);

        // T2: warm-up output carries 0x1234 and must be discarded
        reset = 1'b1; en = 1'b1; gen_valid = 1'b1;
        gen_x0 = 16'h1234; gen_x1 = 16'h4321;
        warmup_count(runs);
        chk("t1_warm_clks", 64'(runs), 64'(PIPE_LAT));

        gen_x0 = 16'hA5A5; gen_x1 = 16'h5A5A;
        step();
        gen_valid = 1'b0; req = 4'b1000;
        step();
        chk("t2_first_grant", 64'(grant),  64'h8);
        chk("t2_first_x0",    64'(out_x0), 64'hA5A5);
        chk("t2_first_x1",    64'(out_x1), 64'h5A5A);
        req = '0;

        // T3: all requesting, FIFO fed every cycle -> strict rotation
        req = 4'b1111; gen_valid = 1'b1;
        gen_x0 = rand_w(); gen_x1 = rand_w();
        step();
        for (int k = 0; k < 8; k++) begin
            prev_cnt = sample_cnt;
            gen_x0 = rand_w(); gen_x1 = rand_w();
            step();
            chk("t3_rotation", 64'(grant),      64'(NREQ'(1) << (k % NREQ)));
            chk("t3_cnt_inc",  64'(sample_cnt), 64'(prev_cnt + 32'd1));
        end

        // T4: fill FIFO with no requests, then a single requester
        req = '0;
        for (int i = 0; i < 10; i++) begin
            if (level == LW'(DEPTH)) break;
            gen_x0 = rand_w(); gen_x1 = rand_w();
            step();
        end
        chk("t4_full_level",   64'(level),   64'(DEPTH));
        chk("t4_full_gen_run", 64'(gen_run), 64'd0);
        req = 4'b0100;
        step();
        chk("t4_grant2",   64'(grant),   64'h4);
        chk("t4_level3",   64'(level),   64'd3);
        chk("t4_gen_run1", 64'(gen_run), 64'd1);
        req = '0;

        // T5: en low drains the FIFO, generator stops; en high resumes without warm-up
        en = 1'b0; gen_valid = 1'b0; req = 4'b0001;
        ngr = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (grant != '0) ngr++;
        end
        chk("t5_grants",  64'(ngr),     64'd3);
        chk("t5_level",   64'(level),   64'd0);
        chk("t5_gen_run", 64'(gen_run), 64'd0);
        en = 1'b1; req = '0; gen_valid = 1'b1;
        gen_x0 = rand_w(); gen_x1 = rand_w();
        step();
        chk("t5_resume_run", 64'(gen_run), 64'd1);
        step();
        chk("t5_resume_push", 64'(level), 64'd1);

        // T6: flush beats simultaneous push and grant
        gen_x0 = rand_w(); gen_x1 = rand_w();
        step();
        flush = 1'b1; req = 4'b1111;
        step();
        chk("t6_flush_level", 64'(level), 64'd0);
        chk("t6_flush_grant", 64'(grant), 64'd0);
        chk("t6_flush_warm",  64'(warm),  64'd1);
        flush = 1'b0; req = '0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 15) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            gen_valid = ($urandom_range(0, 3) != 0);
            req       = NREQ'($urandom);
            gen_x0    = rand_w();
            gen_x1    = rand_w();
            step();
        end

        // Reset mid-run aborts everything and forces a fresh warm-up
        en = 1'b1; flush = 1'b0; req = 4'b1111; gen_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        step();
        chk("t6_rst_level", 64'(level),      64'd0);
        chk("t6_rst_warm",  64'(warm),       64'd0);
        chk("t6_rst_cnt",   64'(sample_cnt), 64'd0);
        reset = 1'b1; req = '0;
        warmup_count(runs);
        chk("t6_rewarm_clks", 64'(runs), 64'(PIPE_LAT));

        chk("t2_discard_1234", 64'(seen_1234), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
